// File: rtl/inv_cipher_core_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the inverse cipher core.
package inv_cipher_core_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int RIDX_W     = 4;

  // Byte i of the state is row i%4, column i/4; byte 0 sits in the MSBs.
  typedef logic [0:15][7:0]   state_t;
  // Word c is column c; bits [31:24] hold row 0.
  typedef logic [0:3][31:0]   rkey_t;
  typedef logic [RIDX_W-1:0]  ridx_t;

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Row r rotates right by r columns.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
    return o;
  endfunction

  function automatic state_t add_round_key(input state_t s, input rkey_t k);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r + 4*c] = s[r + 4*c] ^ k[c][31-8*r -: 8];
    return o;
  endfunction

  // Column-wise multiply by the circulant matrix {0e,0b,0d,09}.
  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c+1];
      a2 = s[4*c+2];
      a3 = s[4*c+3];
      o[4*c]   = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
      o[4*c+1] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
      o[4*c+2] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
      o[4*c+3] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_cipher_core_if.sv
// Block interface between the inverse cipher core and its surroundings.
interface inv_cipher_core_if;
  import inv_cipher_core_pkg::*;

  logic   start;
  state_t cipher_in;
  ridx_t  key_round;
  rkey_t  round_key;
  state_t plain_out;
  logic   busy;
  logic   done;

  modport master (
    output start, cipher_in, round_key,
    input  key_round, plain_out, busy, done
  );

  modport slave (
    input  start, cipher_in, round_key,
    output key_round, plain_out, busy, done
  );

endinterface

// File: rtl/inv_cipher_core_inv_sbox.sv
// Combinational AES inverse S-box lookup.
module inv_cipher_core_inv_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // NOTE: a constant ROM carries no state, so it needs no reset.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_cipher_core.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// requested from the shared key store by index, 10 down to 0.
module inv_cipher_core
  import inv_cipher_core_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  inv_cipher_core_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] fsm;
  state_t     st;
  ridx_t      cnt;

  state_t     sr;
  state_t     sb;
  state_t     ark;
  state_t     round_out;
  ridx_t      key_idx;

  assign sr = inv_shift_rows(st);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_cipher_core_inv_sbox u_sbox (
      .din  (sr[i]),
      .dout (sb[i])
    );
  end

  assign ark = add_round_key(sb, bus.round_key);

  // Round result; the final round bypasses InvMixColumns.
  always_comb begin
    round_out = inv_mix_columns(ark);
    if (fsm == S_FINAL) round_out = ark;
  end

  // Round-key index requested from the key store this cycle.
  always_comb begin
    // NOTE: default first so every path assigns key_idx and no latch is inferred.
    key_idx = ridx_t'(NUM_ROUNDS);
    case (fsm)
      S_RUN:   key_idx = cnt;
      S_FINAL: key_idx = '0;
      default: key_idx = ridx_t'(NUM_ROUNDS);
    endcase
  end

  // FSM, round counter and state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      fsm <= S_IDLE;
      st  <= '0;
      cnt <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (bus.start) begin
            st  <= add_round_key(bus.cipher_in, bus.round_key);
            cnt <= ridx_t'(NUM_ROUNDS - 1);
            fsm <= S_RUN;
          end
        end
        S_RUN: begin
          st  <= round_out;
          cnt <= cnt - ridx_t'(1);
          if (cnt == ridx_t'(1)) fsm <= S_FINAL;
        end
        S_FINAL: begin
          st  <= round_out;
          fsm <= S_DONE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign bus.key_round = key_idx;
  assign bus.plain_out = st;
  assign bus.busy      = (fsm == S_RUN) || (fsm == S_FINAL);
  assign bus.done      = (fsm == S_DONE);

endmodule
